// File: rtl/hfilt121_stream.sv
`default_nettype none
// ============================================================================
//  Module      : hfilt121_stream
//  Description : Horizontal [1 2 1]/4 smoothing filter over a stream of
//                64-bit words carrying eight 8-bit pixels each (pixel 0 in
//                the low byte). Line edges replicate the edge pixel; pixels
//                never mix across lines. One output word per input word.
//  Revision    : 1.0 - initial release
// ============================================================================
module hfilt121_stream #(
    parameter int LINE_WORDS = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [15:0] lines_done
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [11:0] C_LAST_POS = 12'(LINE_WORDS - 1);

    state_t      state_q, state_d;
    logic [11:0] pos_q, pos_d;
    logic [63:0] hold_q, hold_d;
    logic [7:0]  left_q, left_d;
    logic [63:0] dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic [15:0] lines_done_q, lines_done_d;

    logic        w_out_free;
    logic        w_accept;

    // Filter one word given its outer neighbours; the word is framed as
    // {right, word, left} so every tap is a plain in-range slice.
    function automatic logic [63:0] filt8(input logic [63:0] w,
                                          input logic [7:0]  l,
                                          input logic [7:0]  r);
        logic [79:0] ext;
        logic [63:0] o;
        logic [9:0]  s;
        ext = {r, w, l};
        o   = '0;
        for (int i = 0; i < 8; i++) begin
            s = {2'b00, ext[8*i +: 8]}
              + {1'b0, ext[8*(i+1) +: 8], 1'b0}
              + {2'b00, ext[8*(i+2) +: 8]}
              + 10'd2;
            o[8*i +: 8] = s[9:2];
        end
        return o;
    endfunction

    assign w_out_free = !dout_valid_q || dout_ready;
    assign din_ready  = (state_q != S_FLUSH) && w_out_free;
    // Clear swallows the cycle: a word presented alongside it is not taken.
    assign w_accept   = din_valid && din_ready && !clear;

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign lines_done = lines_done_q;

    // Next-state logic: FSM transitions, output register loads, line counting.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        hold_d       = hold_q;
        left_d       = left_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        lines_done_d = lines_done_q;

        if (clear) begin
            state_d      = S_EMPTY;
            pos_d        = '0;
            hold_d       = '0;
            left_d       = '0;
            dout_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        hold_d = din;
                        left_d = din[7:0];
                        if (LINE_WORDS == 1) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = S_HOLD;
                            pos_d   = 12'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        dout_d       = filt8(hold_q, left_q, din[7:0]);
                        dout_valid_d = 1'b1;
                        left_d       = hold_q[63:56];
                        hold_d       = din;
                        if (pos_q == C_LAST_POS) begin
                            state_d = S_FLUSH;
                        end else begin
                            pos_d = pos_q + 12'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_out_free) begin
                        dout_d       = filt8(hold_q, left_q, hold_q[63:56]);
                        dout_valid_d = 1'b1;
                        lines_done_d = lines_done_q + 16'd1;
                        pos_d        = '0;
                        state_d      = S_EMPTY;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    pos_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            pos_q        <= '0;
            hold_q       <= '0;
            left_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            lines_done_q <= '0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            hold_q       <= hold_d;
            left_q       <= left_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            lines_done_q <= lines_done_d;
        end
    end

endmodule
`default_nettype wire
